toggle_mon_bank: RTL and testbench

Parametrised successor to the single-bit inverter cells. It is a WIDTH-lane registered inverter bank with per-lane toggle-activity counters measured over a fixed window. After the window closes, the lane counts are read out one lane per handshake. It sits beside netlist-level cells so the thermal flow can derive switching activity, and therefore power, from simulated stimulus.

---
 rtl/toggle_mon_pkg.sv | 20 ++
 rtl/toggle_mon_lane.sv | 43 ++++
 rtl/toggle_mon_bank.sv | 121 ++++++++++++
 tb/tb_toggle_mon_bank.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/toggle_mon_pkg.sv
// Shared definitions for the toggle-activity monitor bank: FSM states,
// default sizes and the window-counter width helper.
package toggle_mon_pkg;

    typedef enum logic [1:0] {
        IDLE,
        COUNT,
        DUMP
    } state_t;

    localparam int DEF_WIDTH  = 23;
    localparam int DEF_CNT_W  = 16;
    localparam int DEF_WINDOW = 256;

    // The window counter must be able to hold WINDOW itself, not just WINDOW-1.
    function automatic int win_cnt_w(input int window);
        return $clog2(window + 1);
    endfunction

endpackage

// File: rtl/toggle_mon_lane.sv
// One inverter lane: a registered y bit plus its toggle counter.
// Define TOGGLE_MON_SAT_EN to saturate the counter instead of wrapping.
module toggle_mon_lane #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a,
    input  logic             en,
    input  logic             clr,
    input  logic             cnt_en,
    output logic             y,
    output logic [CNT_W-1:0] count
);

    logic             toggle;
    logic [CNT_W-1:0] count_inc;

    assign toggle = en && (~a != y);

`ifdef TOGGLE_MON_SAT_EN
    assign count_inc = (count == '1) ? count : count + CNT_W'(1);
`else
    assign count_inc = count + CNT_W'(1);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y     <= 1'b0;
            count <= '0;
        end else begin
            if (en) begin
                y <= ~a;
            end
            if (clr) begin
                count <= '0;
            end else if (cnt_en && toggle) begin
                count <= count_inc;
            end
        end
    end

endmodule

// File: rtl/toggle_mon_bank.sv
// WIDTH-lane registered inverter bank with per-lane toggle counters measured
// over a WINDOW-edge window, then read out one lane per handshake.
// Build option: TOGGLE_MON_SAT_EN (saturating lane counters; default wraps).
module toggle_mon_bank
    import toggle_mon_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int CNT_W  = DEF_CNT_W,
    parameter int WINDOW = DEF_WINDOW
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic [WIDTH-1:0]                          a,
    input  logic                                      en,
    input  logic                                      start,
    output logic [WIDTH-1:0]                          y,
    output logic                                      busy,
    output logic                                      rd_valid,
    input  logic                                      rd_ready,
    output logic [(WIDTH > 1 ? $clog2(WIDTH) : 1)-1:0] rd_lane,
    output logic [CNT_W-1:0]                          rd_count
);

    localparam int LW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int WW = win_cnt_w(WINDOW);

    state_t           state;
    state_t           next_state;
    logic [WW-1:0]    win_cnt;
    logic             win_clr;
    logic             win_active;
    logic             win_last;
    logic             lane_last;
    logic [CNT_W-1:0] counts [WIDTH];

    assign win_last  = (win_cnt == WW'(WINDOW - 1));
    assign lane_last = (rd_lane == LW'(WIDTH - 1));

    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        toggle_mon_lane #(
            .CNT_W(CNT_W)
        ) u_lane (
            .clk    (clk),
            .rst    (rst),
            .a      (a[i]),
            .en     (en),
            .clr    (win_clr),
            .cnt_en (win_active),
            .y      (y[i]),
            .count  (counts[i])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        win_clr    = 1'b0;
        win_active = 1'b0;
        busy       = 1'b0;
        rd_valid   = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    next_state = COUNT;
                    win_clr    = 1'b1;
                end
            end
            COUNT: begin
                busy       = 1'b1;
                win_active = 1'b1;
                if (win_last) begin
                    next_state = DUMP;
                end
            end
            DUMP: begin
                busy     = 1'b1;
                rd_valid = 1'b1;
                if (rd_ready && lane_last) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // The window counter ends one past WINDOW-1 and simply parks there until the next start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win_cnt <= '0;
        end else if (win_clr) begin
            win_cnt <= '0;
        end else if (win_active) begin
            win_cnt <= win_cnt + WW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_lane <= '0;
        end else if (rd_valid && rd_ready) begin
            rd_lane <= lane_last ? '0 : rd_lane + LW'(1);
        end
    end

    always_comb begin
        rd_count = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (rd_lane == LW'(i)) begin
                rd_count = counts[i];
            end
        end
    end

endmodule

// File: tb/tb_toggle_mon_bank.sv
// Self-checking bench for toggle_mon_bank: two instances (CNT_W=4 and CNT_W=2)
// share stimulus and are checked against a toggle-counting reference model.
module tb_toggle_mon_bank;

    localparam int W   = 4;
    localparam int WIN = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         en;
    logic         start;
    logic         rd_ready;
    logic [W-1:0] a;
    logic [W-1:0] y;
    logic [W-1:0] y2;
    logic         busy;
    logic         busy2;
    logic         rd_valid;
    logic         rd_valid2;
    logic [1:0]   rd_lane;
    logic [1:0]   rd_lane2;
    logic [3:0]   rd_count;
    logic [1:0]   rd_count2;

    int           checks = 0;
    int           errors = 0;
    logic [W-1:0] ym;
    int           mcount [W];
    bit           counting;

    always #5 clk = ~clk;

    toggle_mon_bank #(.WIDTH(W), .CNT_W(4), .WINDOW(WIN)) u_dut (
        .clk(clk), .rst(rst), .a(a), .en(en), .start(start), .y(y),
        .busy(busy), .rd_valid(rd_valid), .rd_ready(rd_ready),
        .rd_lane(rd_lane), .rd_count(rd_count)
    );

    toggle_mon_bank #(.WIDTH(W), .CNT_W(2), .WINDOW(WIN)) u_dut2 (
        .clk(clk), .rst(rst), .a(a), .en(en), .start(start), .y(y2),
        .busy(busy2), .rd_valid(rd_valid2), .rd_ready(rd_ready),
        .rd_lane(rd_lane2), .rd_count(rd_count2)
    );

    function automatic int exp1(input int c);
        return c % 16;
    endfunction

    function automatic int exp2(input int c);
`ifdef TOGGLE_MON_SAT_EN
        return (c > 3) ? 3 : c;
`else
        return c % 4;
`endif
    endfunction

    // One clock edge: update the reference inverter and toggle tallies, then check y.
    task automatic tick();
        @(posedge clk);
        if (en) begin
            for (int i = 0; i < W; i++) begin
                if (counting && (~a[i] != ym[i])) mcount[i]++;
            end
            ym = ~a;
        end
        #1;
        checks++;
        if (y !== ym || y2 !== ym) begin
            errors++;
            $display("[TB] FAIL y: got %b/%b expected %b", y, y2, ym);
        end
    endtask

    task automatic do_window(input bit rand_a, input bit rand_en, input int en_off_from, input int extra_start_at);
        bit exp_v;
        for (int i = 0; i < W; i++) mcount[i] = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || busy2 !== 1'b1 || rd_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL start_busy: got busy=%b/%b rd_valid=%b expected 1/1/0", busy, busy2, rd_valid);
        end
        for (int e = 0; e < WIN; e++) begin
            if (rand_a) a = W'($urandom);
            else        a[0] = ~a[0];
            en = rand_en ? ($urandom_range(0, 3) != 0) : (e < en_off_from);
            start = (e == extra_start_at);
            counting = 1'b1;
            tick();
            counting = 1'b0;
            exp_v = (e == WIN - 1);
            checks++;
            if (rd_valid !== exp_v || rd_valid2 !== exp_v || busy !== 1'b1) begin
                errors++;
                $display("[TB] FAIL window_edge%0d: got rd_valid=%b/%b busy=%b expected %b/%b/1",
                         e, rd_valid, rd_valid2, busy, exp_v, exp_v);
            end
        end
        start = 1'b0;
        en = 1'b1;
    endtask

    task automatic read_out(input int stall0, input bit rnd_stall, input bit start_on_last);
        int st;
        for (int l = 0; l < W; l++) begin
            st = (l == 0) ? stall0 : (rnd_stall ? int'($urandom_range(0, 2)) : 0);
            for (int s = 0; s <= st; s++) begin
                rd_ready = (s == st);
                start = start_on_last && (l == W - 1) && (s == st);
                checks++;
                if (rd_valid !== 1'b1 || rd_lane !== 2'(l) || rd_count !== 4'(exp1(mcount[l])) ||
                    rd_valid2 !== 1'b1 || rd_lane2 !== 2'(l) || rd_count2 !== 2'(exp2(mcount[l]))) begin
                    errors++;
                    $display("[TB] FAIL readout: got v=%b lane=%0d cnt=%0d | v=%b lane=%0d cnt=%0d expected lane=%0d cnt=%0d | cnt=%0d",
                             rd_valid, rd_lane, rd_count, rd_valid2, rd_lane2, rd_count2,
                             l, exp1(mcount[l]), exp2(mcount[l]));
                end
                tick();
            end
        end
        rd_ready = 1'b0;
        start = 1'b0;
        checks++;
        if (busy !== 1'b0 || busy2 !== 1'b0 || rd_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL dump_done: got busy=%b/%b rd_valid=%b expected 0/0/0", busy, busy2, rd_valid);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; a = '0; en = 1'b0; start = 1'b0; rd_ready = 1'b0;
        counting = 1'b0; ym = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (y !== '0 || busy !== 1'b0 || rd_valid !== 1'b0 || rd_lane !== 2'd0 || rd_count !== 4'd0) begin
            errors++;
            $display("[TB] FAIL reset_values: got y=%b busy=%b v=%b lane=%0d cnt=%0d expected all 0",
                     y, busy, rd_valid, rd_lane, rd_count);
        end
        rst = 1'b0;
        a = 4'b0101;
        en = 1'b1;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL busy_after_start: got %b expected 1", busy);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (y !== '0 || busy !== 1'b0 || rd_valid !== 1'b0 || rd_lane !== 2'd0) begin
            errors++;
            $display("[TB] FAIL async_reset_count: got y=%b busy=%b v=%b lane=%0d expected 0000/0/0/0",
                     y, busy, rd_valid, rd_lane);
        end
        ym = '0;
        #1 rst = 1'b0;
    endtask

    task automatic test_basic();
        a = 4'b1110;
        en = 1'b1;
        tick();
        checks++;
        if (y !== 4'b0001) begin
            errors++;
            $display("[TB] FAIL basic_y: got %b expected 0001", y);
        end
        do_window(1'b0, 1'b0, WIN, -1);
        checks++;
        if (rd_count !== 4'd8) begin
            errors++;
            $display("[TB] FAIL basic_lane0: got %0d expected 8", rd_count);
        end
        read_out(0, 1'b0, 1'b0);
    endtask

    task automatic test_backpressure();
        do_window(1'b1, 1'b0, WIN, -1);
        read_out(3, 1'b0, 1'b0);
    endtask

    task automatic test_enable_start();
        a = 4'b1110;
        en = 1'b1;
        tick();
        do_window(1'b0, 1'b0, WIN - 3, 3);
        checks++;
        if (rd_count !== 4'd5) begin
            errors++;
            $display("[TB] FAIL enable_lane0: got %0d expected 5", rd_count);
        end
        read_out(0, 1'b0, 1'b0);
    endtask

    task automatic test_reset_in_dump();
        do_window(1'b1, 1'b0, WIN, -1);
        rd_ready = 1'b1;
        tick();
        tick();
        rd_ready = 1'b0;
        checks++;
        if (rd_lane !== 2'd2 || rd_valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL dump_lane2: got lane=%0d v=%b expected 2/1", rd_lane, rd_valid);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (rd_valid !== 1'b0 || busy !== 1'b0 || rd_lane !== 2'd0 || rd_count !== 4'd0 || y !== '0) begin
            errors++;
            $display("[TB] FAIL async_reset_dump: got v=%b busy=%b lane=%0d cnt=%0d y=%b expected 0/0/0/0/0000",
                     rd_valid, busy, rd_lane, rd_count, y);
        end
        ym = '0;
        #1 rst = 1'b0;
        do_window(1'b1, 1'b1, WIN, -1);
        read_out(0, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        repeat (4) begin
            do_window(1'b1, 1'b1, WIN, -1);
            read_out(int'($urandom_range(0, 2)), 1'b1, 1'b0);
        end
    endtask

    task automatic test_back_to_back();
        do_window(1'b1, 1'b1, WIN, -1);
        read_out(0, 1'b0, 1'b1);
        tick();
        checks++;
        if (busy !== 1'b0 || busy2 !== 1'b0) begin
            errors++;
            $display("[TB] FAIL start_on_exit_ignored: got busy=%b/%b expected 0/0", busy, busy2);
        end
        do_window(1'b1, 1'b0, WIN, -1);
        read_out(1, 1'b0, 1'b0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_enable_start();
        test_reset_in_dump();
        test_random();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
